la_operand_bridge: RTL

Parametrised logic-analyzer command bridge between the management SoC's LA probes and a wide-operand compute core, such as the BEC point-arithmetic core. It generalises operand width, chunk width, operand count and result count. Transfers use a tag-toggle handshake, so a command held on the probes executes exactly once. The bridge also adds load-completeness checking, abort, a run timeout and error reporting, and sits in the user project between `la_data_in`/`la_data_out` and the core.

---
 rtl/la_bridge_pkg.sv | 38 +++
 rtl/la_operand_bridge_if.sv | 9 +
 rtl/la_cmd_decode.sv | 53 +++++
 rtl/la_operand_bridge.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/la_bridge_pkg.sv
// Shared opcodes, state/error encodings and sizing helper for the LA operand bridge.
package la_bridge_pkg;

  localparam logic [7:0] OpWrite   = 8'h30;
  localparam logic [7:0] OpStart   = 8'h41;
  localparam logic [7:0] OpRead    = 8'h0C;
  localparam logic [7:0] OpRelease = 8'h10;
  localparam logic [7:0] OpAbort   = 8'h5A;
  localparam logic [7:0] OpNop     = 8'h00;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  localparam logic [7:0] CodeIdle = 8'h01;
  localparam logic [7:0] CodeLoad = 8'h02;
  localparam logic [7:0] CodeRun  = 8'h04;
  localparam logic [7:0] CodeDone = 8'h08;

  localparam logic [7:0] ErrNone       = 8'd0;
  localparam logic [7:0] ErrOpcode     = 8'd1;
  localparam logic [7:0] ErrAddr       = 8'd2;
  localparam logic [7:0] ErrBusy       = 8'd3;
  localparam logic [7:0] ErrIncomplete = 8'd4;
  localparam logic [7:0] ErrTimeout    = 8'd5;

  function automatic logic [7:0] state_code(state_e s);
    case (s)
      StIdle:  return CodeIdle;
      StLoad:  return CodeLoad;
      StRun:   return CodeRun;
      default: return CodeDone;
    endcase
  endfunction

  function automatic int unsigned nchunk(int unsigned op_w, int unsigned chunk_w);
    return (op_w + chunk_w - 1) / chunk_w;
  endfunction

endpackage

// File: rtl/la_operand_bridge_if.sv
// Logic-analyzer probe bus between the management SoC (master) and the bridge (slave).
interface la_operand_bridge_if;
  logic [127:0] la_data_in;
  logic [127:0] la_oenb;
  logic [127:0] la_data_out;

  modport master (output la_data_in, output la_oenb, input la_data_out);
  modport slave (input la_data_in, input la_oenb, output la_data_out);
endinterface

// File: rtl/la_cmd_decode.sv
// Registers LA commands, accepting each only once per tag change while oenb enables the fields.
module la_cmd_decode (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [127:8]  i_la_cmd,
  input  logic [31:8]   i_la_oenb,
  output logic          o_cmd_valid,
  output logic [7:0]    o_opcode,
  output logic [7:0]    o_addr,
  output logic [7:0]    o_tag,
  output logic [95:0]   o_payload
);

  logic [7:0]  r_last_tag;
  logic        r_cmd_valid;
  logic [7:0]  r_opcode;
  logic [7:0]  r_addr;
  logic [7:0]  r_tag;
  logic [95:0] r_payload;

  logic [7:0] w_tag;
  logic       w_valid;

  assign w_tag   = i_la_cmd[15:8];
  assign w_valid = (i_la_oenb == 24'h0) && (w_tag != r_last_tag);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_tag  <= 8'h00;
      r_cmd_valid <= 1'b0;
      r_opcode    <= 8'h00;
      r_addr      <= 8'h00;
      r_tag       <= 8'h00;
      r_payload   <= '0;
    end else begin
      r_cmd_valid <= w_valid;
      if (w_valid) begin
        r_last_tag <= w_tag;
        r_tag      <= w_tag;
        r_opcode   <= i_la_cmd[31:24];
        r_addr     <= i_la_cmd[23:16];
        r_payload  <= i_la_cmd[127:32];
      end
    end
  end

  assign o_cmd_valid = r_cmd_valid;
  assign o_opcode    = r_opcode;
  assign o_addr      = r_addr;
  assign o_tag       = r_tag;
  assign o_payload   = r_payload;

endmodule

// File: rtl/la_operand_bridge.sv
// LA command bridge: chunked operand load, start/abort/timeout control and result readback.
module la_operand_bridge
  import la_bridge_pkg::*;
#(
  parameter int unsigned OP_W        = 163,
  parameter int unsigned CHUNK_W     = 82,
  parameter int unsigned N_IN        = 7,
  parameter int unsigned N_OUT       = 2,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  la_operand_bridge_if.slave      la_bus,
  output logic [N_IN*OP_W-1:0]    core_operands,
  output logic                    core_start,
  output logic                    core_abort,
  input  logic                    core_done,
  input  logic [N_OUT*OP_W-1:0]   core_results
);

  localparam int unsigned NChunk    = nchunk(OP_W, CHUNK_W);
  localparam int unsigned InChunks  = N_IN * NChunk;
  localparam int unsigned OutChunks = N_OUT * NChunk;

  logic        w_cmd_valid;
  logic [7:0]  w_opcode;
  logic [7:0]  w_addr;
  logic [7:0]  w_tag;
  logic [95:0] w_payload;

  la_cmd_decode u_decode (
    .i_clk       (wb_clk_i),
    .i_rst       (wb_rst_i),
    .i_la_cmd    (la_bus.la_data_in[127:8]),
    .i_la_oenb   (la_bus.la_oenb[31:8]),
    .o_cmd_valid (w_cmd_valid),
    .o_opcode    (w_opcode),
    .o_addr      (w_addr),
    .o_tag       (w_tag),
    .o_payload   (w_payload)
  );

  logic w_unused_la;
  assign w_unused_la = ^{la_bus.la_data_in[7:0], la_bus.la_oenb[127:32], la_bus.la_oenb[7:0],
                         w_payload};

  state_e                r_state, w_state_d;
  logic [InChunks-1:0]   r_loaded, w_loaded_d;
  logic [15:0]           r_cnt, w_cnt_d;
  logic [N_IN*OP_W-1:0]  r_operands, w_ops_d;
  logic [N_OUT*OP_W-1:0] r_results;
  logic                  r_core_start, w_start_d;
  logic                  r_core_abort, w_abort_d;
  logic [95:0]           r_out_payload, w_payload_d;
  logic [7:0]            r_out_state;
  logic [7:0]            r_out_addr, w_addr_d;
  logic [7:0]            r_out_tag, w_tag_d;
  logic [7:0]            r_out_err, w_err_d;
  logic                  w_wr_en;
  logic                  w_cap;
  logic [95:0]           w_rd_chunk;
  logic                  w_in_ok;
  logic                  w_out_ok;

  assign w_in_ok  = 32'(w_addr) < InChunks;
  assign w_out_ok = 32'(w_addr) < OutChunks;

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_start_d   = 1'b0;
    w_abort_d   = 1'b0;
    w_wr_en     = 1'b0;
    w_cap       = 1'b0;
    w_payload_d = r_out_payload;
    w_addr_d    = r_out_addr;
    w_tag_d     = r_out_tag;
    w_err_d     = r_out_err;

    if (w_cmd_valid) begin
      w_addr_d = w_addr;
      w_tag_d  = w_tag;
      w_err_d  = ErrNone;
      case (w_opcode)
        OpNop: ;
        OpAbort: begin
          w_abort_d = (r_state == StRun);
          w_state_d = StIdle;
        end
        OpWrite: begin
          if (r_state == StRun || r_state == StDone) w_err_d = ErrBusy;
          else if (!w_in_ok) w_err_d = ErrAddr;
          else begin
            w_wr_en   = 1'b1;
            w_state_d = StLoad;
          end
        end
        OpStart: begin
          if (r_state == StIdle) w_err_d = ErrIncomplete;
          else if (r_state != StLoad) w_err_d = ErrBusy;
          else if (!(&r_loaded)) w_err_d = ErrIncomplete;
          else begin
            w_start_d = 1'b1;
            w_cnt_d   = 16'd0;
            w_state_d = StRun;
          end
        end
        OpRead: begin
          if (r_state != StDone) w_err_d = ErrBusy;
          else if (!w_out_ok) w_err_d = ErrAddr;
          else w_payload_d = w_rd_chunk;
        end
        OpRelease: begin
          if (r_state == StRun) w_err_d = ErrBusy;
          else if (r_state == StDone) w_state_d = StIdle;
        end
        default: w_err_d = ErrOpcode;
      endcase
    end

    // An accepted ABORT has already left RUN, so it beats a coincident done or timeout.
    if (r_state == StRun && w_state_d == StRun) begin
      if (core_done) begin
        w_cap     = 1'b1;
        w_state_d = StDone;
      end else if (r_cnt + 16'd1 == 16'(TIMEOUT_CYC)) begin
        w_abort_d = 1'b1;
        w_err_d   = ErrTimeout;
        w_state_d = StIdle;
      end else begin
        w_cnt_d = r_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    w_loaded_d = r_loaded;
    if (w_state_d == StIdle) begin
      w_loaded_d = '0;
    end else begin
      for (int unsigned i = 0; i < InChunks; i++) begin
        if (w_wr_en && 32'(w_addr) == i) w_loaded_d[i] = 1'b1;
      end
    end
  end

  // Payload bits past OP_W are dropped on write and read back as zero.
  always_comb begin
    w_ops_d = r_operands;
    for (int unsigned s = 0; s < N_IN; s++) begin
      for (int unsigned c = 0; c < NChunk; c++) begin
        if (w_wr_en && 32'(w_addr) == s * NChunk + c) begin
          for (int unsigned b = 0; b < CHUNK_W && c * CHUNK_W + b < OP_W; b++) begin
            w_ops_d[s * OP_W + c * CHUNK_W + b] = w_payload[b];
          end
        end
      end
    end
  end

  always_comb begin
    w_rd_chunk = '0;
    for (int unsigned s = 0; s < N_OUT; s++) begin
      for (int unsigned c = 0; c < NChunk; c++) begin
        if (32'(w_addr) == s * NChunk + c) begin
          for (int unsigned b = 0; b < CHUNK_W && c * CHUNK_W + b < OP_W; b++) begin
            w_rd_chunk[b] = r_results[s * OP_W + c * CHUNK_W + b];
          end
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state       <= StIdle;
      r_loaded      <= '0;
      r_cnt         <= 16'd0;
      r_operands    <= '0;
      r_results     <= '0;
      r_core_start  <= 1'b0;
      r_core_abort  <= 1'b0;
      r_out_payload <= '0;
      r_out_state   <= CodeIdle;
      r_out_addr    <= 8'h00;
      r_out_tag     <= 8'h00;
      r_out_err     <= ErrNone;
    end else begin
      r_state       <= w_state_d;
      r_loaded      <= w_loaded_d;
      r_cnt         <= w_cnt_d;
      r_operands    <= w_ops_d;
      if (w_cap) r_results <= core_results;
      r_core_start  <= w_start_d;
      r_core_abort  <= w_abort_d;
      r_out_payload <= w_payload_d;
      r_out_state   <= state_code(w_state_d);
      r_out_addr    <= w_addr_d;
      r_out_tag     <= w_tag_d;
      r_out_err     <= w_err_d;
    end
  end

  assign la_bus.la_data_out = {r_out_payload, r_out_state, r_out_addr, r_out_tag, r_out_err};
  assign core_operands      = r_operands;
  assign core_start         = r_core_start;
  assign core_abort         = r_core_abort;

endmodule
